// File: rtl/serial_packet_parser_pkg.sv
// Shared types and constants for the serial packet parser: FSM states, default
// framing parameters and bus widths.
package serial_packet_parser_pkg;

    typedef enum logic [1:0] {
        HUNT,
        LEN,
        PAYLOAD,
        CHECK
    } state_e;

    localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int unsigned MAX_LEN_DEFAULT   = 4;
    localparam int unsigned TIMEOUT_DEFAULT   = 255;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned PKT_DATA_W = 32;
    localparam int unsigned PKT_LEN_W  = 3;

endpackage

// File: rtl/serial_packet_parser_if.sv
// Byte-stream input and decoded-packet output bundle of the serial packet parser.
interface serial_packet_parser_if;
    import serial_packet_parser_pkg::*;

    logic [BYTE_W-1:0]     in_byte;
    logic                  in_valid;
    logic [PKT_DATA_W-1:0] pkt_data;
    logic [PKT_LEN_W-1:0]  pkt_len;
    logic                  pkt_valid;
    logic                  pkt_err;

    modport master (
        output in_byte,
        output in_valid,
        input  pkt_data,
        input  pkt_len,
        input  pkt_valid,
        input  pkt_err
    );

    modport slave (
        input  in_byte,
        input  in_valid,
        output pkt_data,
        output pkt_len,
        output pkt_valid,
        output pkt_err
    );

endinterface

// File: rtl/pkt_timeout_counter.sv
// Inter-byte idle counter: counts idle cycles while enabled and flags the idle
// cycle that would bring the count to TIMEOUT.
module pkt_timeout_counter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] count_q;

    // A byte arriving in the same cycle (clear) always wins over the timeout.
    assign expired = enable && !clear && (count_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (!enable || clear || expired) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/serial_packet_parser.sv
// Frames SYNC/LEN/PAYLOAD/CHECK packets out of a byte stream and reports good
// packets (with assembled payload) or rejected packets as one-cycle pulses.
module serial_packet_parser
    import serial_packet_parser_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT,
    parameter int unsigned MAX_LEN   = MAX_LEN_DEFAULT,
    parameter int unsigned TIMEOUT   = TIMEOUT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    serial_packet_parser_if.slave bus
);

    state_e                state_q, state_n;
    logic [PKT_LEN_W-1:0]  len_q, len_n;
    logic [PKT_LEN_W-1:0]  idx_q, idx_n;
    logic [BYTE_W-1:0]     csum_q, csum_n;
    logic [PKT_DATA_W-1:0] buf_q, buf_n;
    logic [PKT_DATA_W-1:0] pkt_data_q, pkt_data_n;
    logic [PKT_LEN_W-1:0]  pkt_len_q, pkt_len_n;
    logic                  pkt_valid_q, pkt_valid_n;
    logic                  pkt_err_q, pkt_err_n;
    logic                  timeout_c;
    logic                  len_ok_c;
    logic                  cnt_enable_c;

    assign cnt_enable_c = (state_q != HUNT);
    assign len_ok_c     = (bus.in_byte != '0) && (bus.in_byte <= 8'(MAX_LEN));

    pkt_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .enable  (cnt_enable_c),
        .clear   (bus.in_valid),
        .expired (timeout_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= HUNT;
            len_q       <= '0;
            idx_q       <= '0;
            csum_q      <= '0;
            buf_q       <= '0;
            pkt_data_q  <= '0;
            pkt_len_q   <= '0;
            pkt_valid_q <= 1'b0;
            pkt_err_q   <= 1'b0;
        end else begin
            state_q     <= state_n;
            len_q       <= len_n;
            idx_q       <= idx_n;
            csum_q      <= csum_n;
            buf_q       <= buf_n;
            pkt_data_q  <= pkt_data_n;
            pkt_len_q   <= pkt_len_n;
            pkt_valid_q <= pkt_valid_n;
            pkt_err_q   <= pkt_err_n;
        end
    end

    // Next-state and framing decisions; pulses default low every cycle.
    always_comb begin
        state_n     = state_q;
        len_n       = len_q;
        idx_n       = idx_q;
        csum_n      = csum_q;
        buf_n       = buf_q;
        pkt_data_n  = pkt_data_q;
        pkt_len_n   = pkt_len_q;
        pkt_valid_n = 1'b0;
        pkt_err_n   = 1'b0;

        case (state_q)
            HUNT: begin
                if (bus.in_valid && (bus.in_byte == SYNC_BYTE)) begin
                    state_n = LEN;
                end
            end
            LEN: begin
                if (bus.in_valid) begin
                    if (len_ok_c) begin
                        len_n   = PKT_LEN_W'(bus.in_byte);
                        csum_n  = bus.in_byte;
                        idx_n   = '0;
                        buf_n   = '0;
                        state_n = PAYLOAD;
                    end else begin
                        pkt_err_n = 1'b1;
                        state_n   = HUNT;
                    end
                end else if (timeout_c) begin
                    pkt_err_n = 1'b1;
                    state_n   = HUNT;
                end
            end
            PAYLOAD: begin
                if (bus.in_valid) begin
                    // SYNC_BYTE values here are ordinary payload data.
                    buf_n[{idx_q[1:0], 3'b000} +: BYTE_W] = bus.in_byte;
                    csum_n = csum_q ^ bus.in_byte;
                    idx_n  = idx_q + PKT_LEN_W'(1);
                    if (idx_n == len_q) begin
                        state_n = CHECK;
                    end
                end else if (timeout_c) begin
                    pkt_err_n = 1'b1;
                    state_n   = HUNT;
                end
            end
            CHECK: begin
                if (bus.in_valid) begin
                    state_n = HUNT;
                    if (bus.in_byte == csum_q) begin
                        pkt_valid_n = 1'b1;
                        pkt_data_n  = buf_q;
                        pkt_len_n   = len_q;
                    end else begin
                        pkt_err_n = 1'b1;
                    end
                end else if (timeout_c) begin
                    pkt_err_n = 1'b1;
                    state_n   = HUNT;
                end
            end
            default: state_n = HUNT;
        endcase
    end

    assign bus.pkt_data  = pkt_data_q;
    assign bus.pkt_len   = pkt_len_q;
    assign bus.pkt_valid = pkt_valid_q;
    assign bus.pkt_err   = pkt_err_q;

endmodule

// File: tb/tb_serial_packet_parser.sv
// Testbench for serial_packet_parser: directed framing scenarios plus a
// randomized byte stream, checked cycle by cycle against a packet-level model.
module tb_serial_packet_parser;

    localparam logic [7:0]  SYNC = 8'hA5;
    localparam int unsigned MAXL = 4;
    localparam int unsigned TMO  = 255;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    serial_packet_parser_if bus();

    serial_packet_parser #(
        .SYNC_BYTE (SYNC),
        .MAX_LEN   (MAXL),
        .TIMEOUT   (TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int unsigned n_vec;
    int unsigned n_err;

    // Packet-level reference: collects the bytes of the current frame in a queue.
    bit          m_active;
    logic [7:0]  m_pkt[$];
    int unsigned m_idle;
    logic        e_valid, e_err;
    logic [2:0]  e_len;
    logic [31:0] e_data;

    // Observed-pulse tallies for the directed scenarios.
    int unsigned obs_valid, obs_err;
    logic [31:0] obs_data;
    logic [2:0]  obs_len;

    logic [8:0]  stim[$];

    task automatic model_reset();
        m_active = 1'b0;
        m_pkt.delete();
        m_idle  = 0;
        e_valid = 1'b0;
        e_err   = 1'b0;
        e_len   = '0;
        e_data  = '0;
    endtask

    task automatic model_step(input bit v, input logic [7:0] b);
        logic [7:0] x;
        e_valid = 1'b0;
        e_err   = 1'b0;
        if (!m_active) begin
            if (v && b == SYNC) begin
                m_active = 1'b1;
                m_pkt.delete();
                m_idle = 0;
            end
        end else if (!v) begin
            m_idle++;
            if (m_idle == TMO) begin
                e_err    = 1'b1;
                m_active = 1'b0;
            end
        end else begin
            m_idle = 0;
            m_pkt.push_back(b);
            if (m_pkt.size() == 1) begin
                if (b == 8'd0 || b > MAXL) begin
                    e_err    = 1'b1;
                    m_active = 1'b0;
                end
            end else if (m_pkt.size() == int'(m_pkt[0]) + 2) begin
                x = 8'd0;
                for (int i = 0; i < m_pkt.size() - 1; i++) x ^= m_pkt[i];
                if (x == b) begin
                    e_valid = 1'b1;
                    e_len   = 3'(m_pkt[0]);
                    e_data  = 32'd0;
                    for (int i = 1; i <= int'(m_pkt[0]); i++)
                        e_data += 32'(m_pkt[i]) << (8 * (i - 1));
                end else begin
                    e_err = 1'b1;
                end
                m_active = 1'b0;
            end
        end
    endtask

    // Drive one cycle of input from a falling edge; returns at the next falling edge.
    task automatic step(input bit v, input logic [7:0] b);
        bus.in_valid = v;
        bus.in_byte  = v ? b : 8'h00;
        model_step(v, b);
        @(negedge clk);
        obs_valid += int'(bus.pkt_valid);
        obs_err   += int'(bus.pkt_err);
        if (bus.pkt_valid) begin
            obs_data = bus.pkt_data;
            obs_len  = bus.pkt_len;
        end
    endtask

    task automatic push(input logic [7:0] b, input int unsigned gap);
        repeat (gap) stim.push_back(9'h000);
        stim.push_back({1'b1, b});
    endtask

    task automatic clear_tally();
        obs_valid = 0;
        obs_err   = 0;
        obs_data  = 'x;
        obs_len   = 'x;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_byte  = 8'h00;
        model_reset();
        repeat (2) @(negedge clk);
        n_vec++;
        if ({bus.pkt_valid, bus.pkt_err, bus.pkt_len, bus.pkt_data} !== 37'd0) begin
            n_err++;
            $display("FAIL reset_values: got v=%b e=%b len=%0d data=%h, want all zero",
                     bus.pkt_valid, bus.pkt_err, bus.pkt_len, bus.pkt_data);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_good_packet();
        stim.delete();
        clear_tally();
        push(8'hA5, 0); push(8'h02, 9); push(8'h11, 9); push(8'h22, 9); push(8'h31, 9);
        repeat (3) stim.push_back(9'h000);
        foreach (stim[k]) begin
            step(stim[k][8], stim[k][7:0]);
            n_vec++;
            if ({bus.pkt_valid, bus.pkt_err, bus.pkt_len, bus.pkt_data} !== {e_valid, e_err, e_len, e_data}) begin
                n_err++;
                $display("FAIL good_packet cyc %0d: got v=%b e=%b len=%0d data=%h, want v=%b e=%b len=%0d data=%h",
                         k, bus.pkt_valid, bus.pkt_err, bus.pkt_len, bus.pkt_data, e_valid, e_err, e_len, e_data);
            end
        end
        n_vec++;
        if (obs_valid != 1 || obs_err != 0 || obs_data !== 32'h00002211 || obs_len !== 3'd2) begin
            n_err++;
            $display("FAIL good_packet_result: got valids=%0d errs=%0d data=%h len=%0d, want 1 0 00002211 2",
                     obs_valid, obs_err, obs_data, obs_len);
        end
    endtask

    task automatic test_bad_checksum();
        stim.delete();
        clear_tally();
        push(8'hA5, 0); push(8'h01, 0); push(8'h7E, 0); push(8'h00, 0);
        repeat (3) stim.push_back(9'h000);
        foreach (stim[k]) begin
            step(stim[k][8], stim[k][7:0]);
            n_vec++;
            if ({bus.pkt_valid, bus.pkt_err, bus.pkt_len, bus.pkt_data} !== {e_valid, e_err, e_len, e_data}) begin
                n_err++;
                $display("FAIL bad_checksum cyc %0d: got v=%b e=%b len=%0d data=%h, want v=%b e=%b len=%0d data=%h",
                         k, bus.pkt_valid, bus.pkt_err, bus.pkt_len, bus.pkt_data, e_valid, e_err, e_len, e_data);
            end
        end
        n_vec++;
        if (obs_valid != 0 || obs_err != 1 || bus.pkt_data !== 32'h00002211 || bus.pkt_len !== 3'd2) begin
            n_err++;
            $display("FAIL bad_checksum_result: got valids=%0d errs=%0d data=%h len=%0d, want 0 1 00002211 2",
                     obs_valid, obs_err, bus.pkt_data, bus.pkt_len);
        end
    endtask

    task automatic test_bad_length();
        stim.delete();
        clear_tally();
        push(8'hA5, 0); push(8'h05, 0);
        push(8'hA5, 0); push(8'h01, 0); push(8'h10, 0); push(8'h11, 0);
        repeat (2) stim.push_back(9'h000);
        foreach (stim[k]) begin
            step(stim[k][8], stim[k][7:0]);
            n_vec++;
            if ({bus.pkt_valid, bus.pkt_err, bus.pkt_len, bus.pkt_data} !== {e_valid, e_err, e_len, e_data}) begin
                n_err++;
                $display("FAIL bad_length cyc %0d: got v=%b e=%b len=%0d data=%h, want v=%b e=%b len=%0d data=%h",
                         k, bus.pkt_valid, bus.pkt_err, bus.pkt_len, bus.pkt_data, e_valid, e_err, e_len, e_data);
            end
            if (k == 1) begin
                n_vec++;
                if (bus.pkt_err !== 1'b1) begin
                    n_err++;
                    $display("FAIL bad_length_pulse: got err=%b after length byte, want 1", bus.pkt_err);
                end
            end
        end
        n_vec++;
        if (obs_valid != 1 || obs_err != 1 || obs_data !== 32'h00000010 || obs_len !== 3'd1) begin
            n_err++;
            $display("FAIL bad_length_result: got valids=%0d errs=%0d data=%h len=%0d, want 1 1 00000010 1",
                     obs_valid, obs_err, obs_data, obs_len);
        end
    endtask

    task automatic test_timeout();
        int unsigned err_a;
        stim.delete();
        clear_tally();
        push(8'hA5, 0); push(8'h02, 0); push(8'h11, 0);
        repeat (TMO) stim.push_back(9'h000);
        stim.push_back(9'h000);
        foreach (stim[k]) begin
            step(stim[k][8], stim[k][7:0]);
            n_vec++;
            if ({bus.pkt_valid, bus.pkt_err, bus.pkt_len, bus.pkt_data} !== {e_valid, e_err, e_len, e_data}) begin
                n_err++;
                $display("FAIL timeout_expire cyc %0d: got v=%b e=%b len=%0d data=%h, want v=%b e=%b len=%0d data=%h",
                         k, bus.pkt_valid, bus.pkt_err, bus.pkt_len, bus.pkt_data, e_valid, e_err, e_len, e_data);
            end
        end
        err_a = obs_err;
        // Same stream, but the next byte lands on idle cycle TMO.
        stim.delete();
        clear_tally();
        push(8'hA5, 0); push(8'h02, 0); push(8'h11, 0); push(8'h22, TMO - 1); push(8'h31, 0);
        repeat (2) stim.push_back(9'h000);
        foreach (stim[k]) begin
            step(stim[k][8], stim[k][7:0]);
            n_vec++;
            if ({bus.pkt_valid, bus.pkt_err, bus.pkt_len, bus.pkt_data} !== {e_valid, e_err, e_len, e_data}) begin
                n_err++;
                $display("FAIL timeout_boundary cyc %0d: got v=%b e=%b len=%0d data=%h, want v=%b e=%b len=%0d data=%h",
                         k, bus.pkt_valid, bus.pkt_err, bus.pkt_len, bus.pkt_data, e_valid, e_err, e_len, e_data);
            end
        end
        n_vec++;
        if (err_a != 1 || obs_err != 0 || obs_valid != 1 || obs_data !== 32'h00002211) begin
            n_err++;
            $display("FAIL timeout_result: got expire_errs=%0d boundary_errs=%0d valids=%0d data=%h, want 1 0 1 00002211",
                     err_a, obs_err, obs_valid, obs_data);
        end
    endtask

    task automatic test_back_to_back();
        stim.delete();
        clear_tally();
        push(8'hA5, 0); push(8'h04, 0); push(8'hA5, 0); push(8'hA5, 0);
        push(8'hA5, 0); push(8'hA5, 0); push(8'h04, 0);
        push(8'hA5, 0); push(8'h01, 0); push(8'h55, 0); push(8'h54, 0);
        repeat (2) stim.push_back(9'h000);
        foreach (stim[k]) begin
            step(stim[k][8], stim[k][7:0]);
            n_vec++;
            if ({bus.pkt_valid, bus.pkt_err, bus.pkt_len, bus.pkt_data} !== {e_valid, e_err, e_len, e_data}) begin
                n_err++;
                $display("FAIL back_to_back cyc %0d: got v=%b e=%b len=%0d data=%h, want v=%b e=%b len=%0d data=%h",
                         k, bus.pkt_valid, bus.pkt_err, bus.pkt_len, bus.pkt_data, e_valid, e_err, e_len, e_data);
            end
            if (k == 6) begin
                n_vec++;
                if (bus.pkt_valid !== 1'b1 || bus.pkt_data !== 32'hA5A5A5A5 || bus.pkt_len !== 3'd4) begin
                    n_err++;
                    $display("FAIL sync_in_payload: got v=%b data=%h len=%0d, want 1 a5a5a5a5 4",
                             bus.pkt_valid, bus.pkt_data, bus.pkt_len);
                end
            end
        end
        n_vec++;
        if (obs_valid != 2 || obs_err != 0 || obs_data !== 32'h00000055 || obs_len !== 3'd1) begin
            n_err++;
            $display("FAIL back_to_back_result: got valids=%0d errs=%0d data=%h len=%0d, want 2 0 00000055 1",
                     obs_valid, obs_err, obs_data, obs_len);
        end
    endtask

    task automatic test_reset_mid_packet();
        stim.delete();
        clear_tally();
        push(8'hA5, 0); push(8'h04, 0); push(8'hA5, 0);
        foreach (stim[k]) step(stim[k][8], stim[k][7:0]);
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        model_reset();
        repeat (3) begin
            @(negedge clk);
            n_vec++;
            if ({bus.pkt_valid, bus.pkt_err, bus.pkt_len, bus.pkt_data} !== 37'd0) begin
                n_err++;
                $display("FAIL reset_mid_packet: got v=%b e=%b len=%0d data=%h, want all zero",
                         bus.pkt_valid, bus.pkt_err, bus.pkt_len, bus.pkt_data);
            end
        end
        reset = 1'b0;
        stim.delete();
        push(8'hA5, 1); push(8'h02, 0); push(8'h11, 0); push(8'h22, 0); push(8'h31, 0);
        repeat (2) stim.push_back(9'h000);
        foreach (stim[k]) begin
            step(stim[k][8], stim[k][7:0]);
            n_vec++;
            if ({bus.pkt_valid, bus.pkt_err, bus.pkt_len, bus.pkt_data} !== {e_valid, e_err, e_len, e_data}) begin
                n_err++;
                $display("FAIL after_reset cyc %0d: got v=%b e=%b len=%0d data=%h, want v=%b e=%b len=%0d data=%h",
                         k, bus.pkt_valid, bus.pkt_err, bus.pkt_len, bus.pkt_data, e_valid, e_err, e_len, e_data);
            end
        end
        n_vec++;
        if (obs_valid != 1 || obs_err != 0 || obs_data !== 32'h00002211) begin
            n_err++;
            $display("FAIL reset_mid_result: got valids=%0d errs=%0d data=%h, want 1 0 00002211",
                     obs_valid, obs_err, obs_data);
        end
    endtask

    task automatic test_random();
        logic [7:0]  pl[$];
        logic [7:0]  x, b;
        int unsigned len, gap;
        stim.delete();
        for (int p = 0; p < 40; p++) begin
            if ($urandom_range(0, 3) == 0) push(8'($urandom), $urandom_range(0, 2));
            len = $urandom_range(0, 5);
            pl.delete();
            pl.push_back(SYNC);
            pl.push_back(8'(len));
            x = 8'(len);
            for (int i = 0; i < int'(len); i++) begin
                b = 8'($urandom);
                pl.push_back(b);
                x ^= b;
            end
            pl.push_back(($urandom_range(0, 3) == 0) ? (x ^ 8'($urandom_range(1, 255))) : x);
            foreach (pl[i]) begin
                gap = ($urandom_range(0, 24) == 0) ? (TMO - 1 + $urandom_range(0, 2)) : $urandom_range(0, 3);
                push(pl[i], gap);
            end
        end
        repeat (4) stim.push_back(9'h000);
        foreach (stim[k]) begin
            step(stim[k][8], stim[k][7:0]);
            n_vec++;
            if ({bus.pkt_valid, bus.pkt_err, bus.pkt_len, bus.pkt_data} !== {e_valid, e_err, e_len, e_data}) begin
                n_err++;
                $display("FAIL random cyc %0d: got v=%b e=%b len=%0d data=%h, want v=%b e=%b len=%0d data=%h",
                         k, bus.pkt_valid, bus.pkt_err, bus.pkt_len, bus.pkt_data, e_valid, e_err, e_len, e_data);
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        clear_tally();
        @(negedge clk);
        test_reset();
        test_good_packet();
        test_bad_checksum();
        test_bad_length();
        test_timeout();
        test_back_to_back();
        test_reset_mid_packet();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_packet_parser.md
SERIAL_PACKET_PARSER -- requirements
Module: serial_packet_parser

Interface
REQ-001 Parameter SYNC_BYTE, default 8'hA5, is the packet start marker.
REQ-002 Parameter MAX_LEN, default 4, is the maximum payload length in bytes.
REQ-003 Parameter TIMEOUT, default 255, is the number of idle cycles allowed between bytes of one packet.
REQ-004 Port clk, input, 1 bit, is the single clock; all state SHALL change on the rising edge.
REQ-005 Port reset, input, 1 bit, is an asynchronous, active-high reset.
REQ-006 Port in_byte, input, 8 bits, is the received byte from the upstream serial receiver.
REQ-007 Port in_valid, input, 1 bit, is a one-cycle strobe marking in_byte valid; it is driven by the receiver's done output.
REQ-008 Port pkt_data, output, 32 bits, is the assembled payload; payload byte 0 sits in [7:0].
REQ-009 Port pkt_len, output, 3 bits, is the payload length of the last good packet.
REQ-010 Port pkt_valid, output, 1 bit, is a one-cycle pulse marking a good packet.
REQ-011 Port pkt_err, output, 1 bit, is a one-cycle pulse marking a rejected packet.

Function
REQ-012 States SHALL be HUNT, LEN, PAYLOAD and CHECK.
REQ-013 HUNT: in_valid with in_byte==SYNC_BYTE -> LEN; other bytes are discarded.
REQ-014 LEN: on in_valid with 1<=in_byte<=MAX_LEN:
  - latch the length;
  - initialise the running checksum to in_byte;
  - go to PAYLOAD.
REQ-015 LEN: on in_valid with in_byte==0 or in_byte>MAX_LEN -> pulse pkt_err, go to HUNT.
REQ-016 PAYLOAD: on each in_valid:
  - store the byte at lane index*8;
  - XOR the byte into the checksum;
  - after the last byte, go to CHECK.
  A SYNC_BYTE value inside the payload SHALL be treated as data.
REQ-017 CHECK: on in_valid, go to HUNT and pulse exactly one of:
  - pkt_valid, if in_byte equals the checksum;
  - pkt_err, otherwise.
REQ-018 pkt_valid and pkt_err SHALL be registered and SHALL go high in the cycle after the edge that sampled the deciding byte; latency is 1 cycle.
REQ-019 On pkt_valid:
  - pkt_data and pkt_len SHALL update in the same cycle;
  - unused upper byte lanes SHALL be zero.
  On pkt_err, pkt_data and pkt_len SHALL keep their previous values.
REQ-020 In LEN, PAYLOAD and CHECK, an idle counter SHALL:
  - clear on every in_valid;
  - increment on every other cycle.
  When it reaches TIMEOUT: pulse pkt_err, go to HUNT, clear the counter.
REQ-021 If in_valid arrives in the same cycle the counter reaches TIMEOUT, the byte SHALL be accepted and no timeout SHALL occur.
REQ-022 In HUNT the counter SHALL be held at zero.
REQ-023 pkt_valid and pkt_err SHALL never be high in the same cycle.
REQ-024 A new packet MAY begin with the byte immediately after CHECK; no dead cycle is required.

Reset
REQ-025 Reset SHALL be asynchronous and active-high; while reset is high, outputs SHALL hold their reset values.
REQ-026 Reset values:
  - state HUNT;
  - pkt_data 0, pkt_len 0;
  - pkt_valid 0, pkt_err 0;
  - counter 0, checksum 0, byte index 0.
REQ-027 Reset asserted mid-packet SHALL discard the partial packet with no pkt_err pulse.

Structure
REQ-028 A shared package SHALL hold:
  - the state enum;
  - the SYNC_BYTE and MAX_LEN defaults;
  - the 32-bit payload width constant.
REQ-029 The idle counter SHALL be a sub-module named pkt_timeout_counter, with inputs clk, reset, enable, clear and output expired.

Verification
REQ-030 A5 02 11 22 31 with one byte per 10 cycles -> pkt_valid one cycle, pkt_data=32'h00002211, pkt_len=2.
REQ-031 A5 01 7E 00 -> pkt_err one cycle; pkt_data and pkt_len unchanged.
REQ-032 A5 05 -> pkt_err one cycle after the length byte; the following A5 01 10 11 -> pkt_valid, pkt_data=32'h00000010.
REQ-033 Timeout case, TIMEOUT=255:
  - A5 02 11 then 255 idle cycles -> pkt_err, state HUNT;
  - the same stream with a byte arriving on idle cycle 255 -> no pkt_err.
REQ-034 Reset case:
  - A5 04 A5 A5 A5 A5 04 -> pkt_valid, pkt_data=32'hA5A5A5A5;
  - reset asserted after the third byte of a repeat -> no pulse, all outputs 0, and the next full packet is accepted.
